// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: state encoding and symbol constants shared by the TX link scheduler
package tx_sched_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;
    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [7:0] IDLE_BYTE = 8'h00;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter; the pointer moves only when a grant is taken
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);
    logic r_last;
    logic w_pick1;
    // prefer the requester not served last, otherwise whichever one is asking
    always_comb begin
        w_pick1 = i_req[1] && (!i_req[0] || !r_last);
        o_gnt   = i_en ? {w_pick1, i_req[0] && !w_pick1} : 2'b00;
    end
    // remember the served requester; reset favours requester 0 on the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last <= 1'b1;
        else if (i_accept)
            r_last <= o_gnt[1];
    end
endmodule

// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: aligns the link with K28.5, then multiplexes two byte channels with periodic commas
module tx_link_scheduler
    import tx_sched_pkg::*;
#(
    parameter int ALIGN_COUNT  = 16,
    parameter int COMMA_PERIOD = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_en,
    input  logic [7:0] ch0_data,
    input  logic       ch0_valid,
    output logic       ch0_ready,
    input  logic [7:0] ch1_data,
    input  logic       ch1_valid,
    output logic       ch1_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       enc_valid,
    output logic       aligned,
    output logic [1:0] state_o
);
    localparam int            SW         = $clog2(COMMA_PERIOD);
    localparam logic [7:0]    ALIGN_LAST = 8'(ALIGN_COUNT - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(COMMA_PERIOD - 1);

    state_t        r_state;
    logic [7:0]    r_align_cnt;
    logic [SW-1:0] r_slot;
    logic [7:0]    r_enc_data;
    logic          r_enc_k;
    logic          r_enc_valid;
    logic          r_aligned;
    logic          w_data_slot;
    logic [1:0]    w_gnt;
    logic          w_hs;

    assign w_data_slot = (r_state == ST_RUN) && (r_slot != '0);
    assign w_hs        = |(w_gnt & {ch1_valid, ch0_valid});
    assign ch0_ready   = w_gnt[0];
    assign ch1_ready   = w_gnt[1];
    assign enc_data    = r_enc_data;
    assign enc_k       = r_enc_k;
    assign enc_valid   = r_enc_valid;
    assign aligned     = r_aligned;
    assign state_o     = r_state;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_data_slot),
        .i_req    ({ch1_valid, ch0_valid}),
        .i_accept (w_hs),
        .o_gnt    (w_gnt)
    );

    // link FSM; each cycle's decision lands on the encoder outputs one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_align_cnt <= '0;
            r_slot      <= '0;
            r_enc_data  <= IDLE_BYTE;
            r_enc_k     <= 1'b0;
            r_enc_valid <= 1'b0;
            r_aligned   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_enc_data  <= IDLE_BYTE;
                    r_enc_k     <= 1'b0;
                    r_enc_valid <= 1'b0;
                    r_aligned   <= 1'b0;
                    r_align_cnt <= '0;
                    r_slot      <= '0;
                    if (link_en)
                        r_state <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    r_enc_data  <= K28_5;
                    r_enc_k     <= 1'b1;
                    r_enc_valid <= 1'b1;
                    r_aligned   <= 1'b0;
                    r_align_cnt <= r_align_cnt + 8'd1;
                    if (!link_en)
                        r_state <= ST_IDLE;
                    else if (r_align_cnt == ALIGN_LAST) begin
                        r_state <= ST_RUN;
                        r_slot  <= '0;
                    end
                end
                ST_RUN: begin
                    r_enc_data  <= w_gnt[0] ? ch0_data : w_gnt[1] ? ch1_data : K28_5;
                    r_enc_k     <= ~|w_gnt;
                    r_enc_valid <= 1'b1;
                    r_aligned   <= 1'b1;
                    r_slot      <= (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
                    if (!link_en)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_enc_data  <= IDLE_BYTE;
                    r_enc_k     <= 1'b0;
                    r_enc_valid <= 1'b0;
                    r_aligned   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: reference-model and directed checks of the TX link scheduler
module tb_tx_link_scheduler;
    localparam int         AC = 16;
    localparam int         CP = 8;
    localparam logic [7:0] BC = 8'hBC;
    localparam logic [8:0] E36 [12] = '{9'h1BC, 9'h000, 9'h001, 9'h002, 9'h003, 9'h004,
                                        9'h005, 9'h006, 9'h1BC, 9'h007, 9'h008, 9'h009};
    localparam logic [8:0] E37 [11] = '{9'h1BC, 9'h0A5, 9'h05A, 9'h0A5, 9'h05A, 9'h0A5,
                                        9'h05A, 9'h0A5, 9'h1BC, 9'h05A, 9'h0A5};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       link_en = 1'b0;
    logic [7:0] ch0_data = 8'h00;
    logic [7:0] ch1_data = 8'h00;
    logic       ch0_valid = 1'b0;
    logic       ch1_valid = 1'b0;
    logic       ch0_ready, ch1_ready, enc_k, enc_valid, aligned;
    logic [7:0] enc_data;
    logic [1:0] state_o;

    int n_chk = 0;
    int n_err = 0;

    logic       rec = 1'b0;
    logic [8:0] lg [64];
    int         lg_n = 0;

    always #5 clk = ~clk;

    tx_link_scheduler #(.ALIGN_COUNT(AC), .COMMA_PERIOD(CP)) dut (
        .clk       (clk),
        .rst       (rst),
        .link_en   (link_en),
        .ch0_data  (ch0_data),
        .ch0_valid (ch0_valid),
        .ch0_ready (ch0_ready),
        .ch1_data  (ch1_data),
        .ch1_valid (ch1_valid),
        .ch1_ready (ch1_ready),
        .enc_data  (enc_data),
        .enc_k     (enc_k),
        .enc_valid (enc_valid),
        .aligned   (aligned),
        .state_o   (state_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: phase, symbols sent in ALIGN, cycles spent in RUN, last served channel
    int         m_st = 0, m_acnt = 0, m_run = 0, m_last = 1;
    logic [7:0] m_data = 8'h00;
    logic       m_k = 1'b0, m_v = 1'b0, m_al = 1'b0;

    always @(negedge clk) begin : compare
        int g;
        int p;
        if (!rst) begin
            m_st = 0; m_acnt = 0; m_run = 0; m_last = 1;
            m_data = 8'h00; m_k = 1'b0; m_v = 1'b0; m_al = 1'b0;
        end
        g = -1;
        if (m_st == 2 && (m_run % CP) != 0) begin
            p = 1 - m_last;
            if (p == 0 ? ch0_valid : ch1_valid) g = p;
            else if (p == 0 ? ch1_valid : ch0_valid) g = 1 - p;
        end
        check("ch0_ready", ch0_ready, g == 0);
        check("ch1_ready", ch1_ready, g == 1);
        check("enc_valid", enc_valid, m_v);
        check("enc_k", enc_k, m_k);
        check("enc_data", enc_data, m_data);
        check("aligned", aligned, m_al);
        check("state_o", state_o, m_st);
        if (rec && enc_valid && aligned && lg_n < 64) begin
            lg[lg_n] = {enc_k, enc_data};
            lg_n++;
        end
        if (rst) begin
            case (m_st)
                0: begin
                    m_v = 1'b0; m_k = 1'b0; m_data = 8'h00; m_al = 1'b0;
                    if (link_en) begin m_st = 1; m_acnt = 0; end
                end
                1: begin
                    m_v = 1'b1; m_k = 1'b1; m_data = BC; m_al = 1'b0;
                    m_acnt++;
                    if (!link_en) m_st = 0;
                    else if (m_acnt == AC) begin m_st = 2; m_run = 0; end
                end
                default: begin
                    m_v = 1'b1; m_al = 1'b1;
                    if (g < 0) begin m_k = 1'b1; m_data = BC; end
                    else begin
                        m_k = 1'b0;
                        m_data = (g == 0) ? ch0_data : ch1_data;
                        m_last = g;
                    end
                    m_run++;
                    if (!link_en) m_st = 0;
                end
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_align(input string name);
        int nbc = 0;
        int done = 0;
        for (int i = 0; i < 60 && done == 0; i++) begin
            @(negedge clk);
            if (aligned) begin
                done = 1;
                check({name, "_first_run_sym"}, {enc_valid, enc_k, enc_data}, {2'b11, BC});
            end else if (enc_valid && enc_k && enc_data == BC) nbc++;
        end
        check({name, "_align_syms"}, nbc, AC);
        check({name, "_aligned_seen"}, done, 1);
        cyc(1);
    endtask

    task automatic stream0();
        int idx = 0;
        bit hs;
        ch0_data = 8'h00;
        ch0_valid = 1'b1;
        for (int t = 0; t < 200 && idx < 10; t++) begin
            @(negedge clk);
            hs = ch0_ready;
            cyc(1);
            if (hs) begin
                idx++;
                ch0_data = 8'(idx);
                ch0_valid = (idx < 10);
            end
        end
        check("r036_stream_done", idx, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int nbad;
        int done;
        #1 rst = 1'b0;
        link_en = 1'b1;
        cyc(3);
        rst = 1'b1;
        lg_n = 0;
        rec = 1'b1;
        fork
            check_align("r035");
            stream0();
        join
        cyc(4);
        rec = 1'b0;
        check("r036_log_len", lg_n >= 12, 1);
        for (int i = 0; i < 12; i++) check($sformatf("r036_sym%0d", i), lg[i], E36[i]);

        lg_n = 0;
        rec = 1'b1;
        cyc(12);
        rec = 1'b0;
        nbad = 0;
        for (int i = 0; i < lg_n; i++) if (lg[i] != 9'h1BC) nbad++;
        check("r038_log_len", lg_n, 12);
        check("r038_non_comma", nbad, 0);

        done = 0;
        for (int t = 0; t < 4 && done == 0; t++) begin
            ch1_data = 8'h77;
            ch1_valid = 1'b1;
            #1;
            if (ch1_ready) begin
                link_en = 1'b0;
                done = 1;
            end else begin
                ch1_valid = 1'b0;
                cyc(1);
            end
        end
        check("r039_hs_found", done, 1);
        cyc(1);
        ch1_valid = 1'b0;
        @(negedge clk);
        check("r039_last_byte", {enc_valid, enc_k, enc_data}, 10'h077 | 10'h200);
        @(negedge clk);
        check("r039_off", {enc_valid, enc_k, enc_data}, 0);
        check("r039_idle", state_o, 0);
        cyc(1);
        link_en = 1'b1;
        check_align("r039_realign");

        cyc(3);
        rst = 1'b0;
        #1;
        check("r040_async_clear", {enc_valid, enc_k, enc_data, aligned, state_o}, 0);
        cyc(2);
        ch0_data = 8'hA5;
        ch1_data = 8'h5A;
        ch0_valid = 1'b1;
        ch1_valid = 1'b1;
        lg_n = 0;
        rec = 1'b1;
        rst = 1'b1;
        check_align("r040");
        cyc(10);
        rec = 1'b0;
        check("r037_log_len", lg_n >= 11, 1);
        for (int i = 0; i < 11; i++) check($sformatf("r037_sym%0d", i), lg[i], E37[i]);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/tx_link_scheduler.md
TX_LINK_SCHEDULER -- requirements
Module: tx_link_scheduler

Interface
REQ-001 Parameter ALIGN_COUNT, default 16, number of K28.5 symbols sent after link enable before data flows (range 1..255).
REQ-002 Parameter COMMA_PERIOD, default 256, number of RUN-state symbol slots per forced comma slot (range 2..65535).
REQ-003 Port clk, input, 1, sole clock; all logic on the rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port link_en, input, 1, level enable for the link; 0 forces IDLE.
REQ-006 Port ch0_data, input, 8, channel-0 payload byte.
REQ-007 Port ch0_valid, input, 1, channel-0 byte available.
REQ-008 Port ch0_ready, output, 1, channel-0 byte accepted this cycle when ch0_valid is also 1.
REQ-009 Port ch1_data, ch1_valid, ch1_ready: same as REQ-006..008, for channel 1.
REQ-010 Port enc_data, output, 8, byte to the 8b/10b encoder data input.
REQ-011 Port enc_k, output, 1, 1 = enc_data is a control symbol (K28.5).
REQ-012 Port enc_valid, output, 1, enc_data/enc_k hold a symbol to encode this cycle.
REQ-013 Port aligned, output, 1, high while in RUN.
REQ-014 Port state_o, output, 2, current state code (IDLE=0, ALIGN=1, RUN=2).

Function
REQ-015 FSM states: IDLE, ALIGN, RUN; encoding per REQ-014; code 3 unreachable, recovers to IDLE.
REQ-016 IDLE->ALIGN when link_en=1; ALIGN->RUN after exactly ALIGN_COUNT symbols emitted in ALIGN; any state->IDLE on the cycle after link_en=0.
REQ-017 enc_data, enc_k, enc_valid are registered; latency from handshake (valid&ready) to byte on enc_data is exactly 1 cycle.
REQ-018 IDLE: enc_valid=0, enc_data=0x00, enc_k=0, both readies 0.
REQ-019 ALIGN: each cycle emits enc_data=0xBC, enc_k=1, enc_valid=1; both readies 0.
REQ-020 RUN: a slot counter (width clog2(COMMA_PERIOD)) increments every cycle, wraps to 0 after COMMA_PERIOD-1; slot 0 is the comma slot.
REQ-021 Comma slot: emits 0xBC/k=1/valid=1; both readies 0 regardless of valid inputs.
REQ-022 Non-comma slot, exactly one channel valid: that channel's ready=1; its byte is emitted with enc_k=0.
REQ-023 Non-comma slot, both valid: round-robin; the channel not granted last gets ready=1; other's ready=0.
REQ-024 Non-comma slot, neither valid: emits idle filler 0xBC/k=1/valid=1; grant pointer unchanged.
REQ-025 Grant pointer updates only on a completed handshake; reset value points so channel 0 wins the first tie.
REQ-026 readies are combinational from state, slot counter, grant pointer and valids; at most one ready high per cycle.
REQ-027 ready never depends on its own channel's data; a channel holding valid is never starved beyond 2 non-comma slots.
REQ-028 Slot counter clears to 0 on entry to RUN (first RUN slot is a comma slot).
REQ-029 link_en falling in RUN: the handshake in that cycle (if any) completes and its byte is emitted; no further handshakes.

Reset
REQ-030 rst=0 asynchronously forces: state IDLE, enc_data=0x00, enc_k=0, enc_valid=0, aligned=0, align and slot counters 0, grant pointer to channel 1 (so channel 0 wins the first tie).
REQ-031 Reset asserted mid-ALIGN or mid-RUN drops outputs immediately; after release, the full ALIGN sequence repeats.

Structure
REQ-032 Package tx_sched_pkg holds the state enum, K28_5 constant (8'hBC) and IDLE_BYTE constant.
REQ-033 One sub-module rr_arbiter2 (two-requester round-robin with enable and grant-accept) is instantiated once.
REQ-034 Block drives the encoder's data port; the encoder is not instantiated here.

Verification
REQ-035 rst low, link_en=1, ALIGN_COUNT=16: after release, 16 cycles of 0xBC/k=1, then aligned=1 and first RUN slot is 0xBC.
REQ-036 RUN, ch0 streams 0x00..0x09 continuously, ch1 idle, COMMA_PERIOD=8: output 0xBC, then 7 data bytes, then 0xBC, then rest in order, none lost.
REQ-037 RUN, both valid constantly (ch0=0xA5, ch1=0x5A): non-comma slots alternate 0xA5/0x5A, channel 0 first.
REQ-038 RUN, no valids: every slot 0xBC/k=1, readies 0.
REQ-039 link_en dropped mid-RUN with handshake pending: that byte appears next cycle, then enc_valid=0; re-enable gives a fresh 16-symbol ALIGN.
REQ-040 rst pulsed low mid-RUN: outputs 0 within the same cycle; recovery as REQ-035.
